bias_bank: RTL and testbench
============================

# bias_bank

Multi-lane, multi-row bias adder with a valid/ready stream interface, sitting between the gate accumulators and the activation units. It holds a DEPTH-row bank of per-lane biases and adds the row selected by an internal auto-advancing row pointer to each accepted beat. Each addition saturates or wraps according to a parameter. It is a bypassable, fully pipelined unit: two-cycle latency, one beat per cycle.

## Interface
- DWIDTH, 16: signed width of one lane of pixel and bias data.
- LANES, 4: lanes processed in parallel per beat.
- DEPTH, 16: bias rows in the bank (2..256).
- AWIDTH, 4: row address width, equal to clog2(DEPTH).
- SAT, 1: 1 = saturating add, 0 = two's-complement wrap.

- clk  in  1  clock, all state on rising edge.
- xrst  in  1  reset; asynchronous and active-high; clears all state.
- enable  in  1  1 = add bias, 0 = bypass; sampled per accepted beat.
- breg_we  in  1  bias row write strobe.
- breg_addr  in  AWIDTH  row written when breg_we=1.
- read_bias  in  LANES*DWIDTH  bias row data, lane 0 in LSBs.
- bias_last  in  AWIDTH  index of last row in a sweep; held static during a sweep.
- start  in  1  restart sweep: row pointer forced to 0.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- pixel_in  in  LANES*DWIDTH  input lanes, signed.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- pixel_out  out  LANES*DWIDTH  result lanes, signed.
- ovf  out  LANES  per-lane overflow flag for the current output beat.
- row_ptr  out  AWIDTH  row the next accepted enabled beat will use.

## Operation
- Bank: DEPTH x LANES registers. A write sets row breg_addr to read_bias at the clock edge. Writes are independent of the stream. Addresses >= DEPTH are ignored.
- Accept: fire = in_valid & in_ready.
  - Stage 1 captures pixel_in, enable, and bank row row_ptr.
  - The row is taken as it was before any same-edge write, so write-during-read returns the old row.
- Row pointer:
  - start=1: the pointer is treated as 0 for the beat accepted this cycle. The next value is then 1, or 0 if that beat is enabled and bias_last=0. If no beat is enabled-accepted, the next value is 0.
  - Otherwise, on fire with enable=1: ptr = (ptr==bias_last) ? 0 : ptr+1.
  - A bypass beat (enable=0) does not advance the pointer.
  - bias_last >= DEPTH: pointer wraps at DEPTH-1.
- Add (stage 2): per lane, s = sext(pixel) + sext(bias) in DWIDTH+1 bits.
  - ovf[i] = 1 if s is outside [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
  - SAT=1: out = clamp(s). SAT=0: out = s[DWIDTH-1:0].
- Bypass beat: pixel_out = pixel_in unchanged and ovf = 0. Latency is the same as an enabled beat, so order is preserved.
- Flow control: advance = !out_valid | out_ready; in_ready = advance.
  - Both stage valids and data move only on advance. On stall, all stage registers hold and pixel_out/ovf stay stable.
  - No beat is dropped or duplicated.
- Reset (xrst=1, any time, including mid-stream):
  - All bank rows, stage data, stage valids, row_ptr, out_valid, pixel_out and ovf go to 0 immediately.
  - in_ready returns 1 after release.
  - In-flight beats are discarded.

## Timing
- Latency: a beat accepted at edge N has out_valid=1 after edge N+2 when out_ready stays high.
- Throughput: one beat per cycle with out_ready held at 1.
- in_ready is combinational from out_valid and out_ready only. There is no path from in_valid to in_ready.
- Bank write at edge N is visible to a beat accepted at edge N+1 or later.
- start with no fire: the pointer resets at that edge and no beat is affected.
- start on the same cycle as the last beat of the previous sweep: the beat uses row 0.

## Test plan
- Basic add, DWIDTH=16, LANES=4, bias_last=1:
  - Stimulus: write row0 = {1,2,3,4}, row1 = {-1,-2,-3,-4}, pulse start, then stream 4 beats of {10,10,10,10}.
  - Required: outputs {11,12,13,14}, {9,8,7,6}, {11,12,13,14}, {9,8,7,6}, each 2 cycles after accept.
- Saturation, SAT=1:
  - Stimulus: pixel 32000 + bias 1000; pixel -32000 + bias -1000.
  - Required: outputs 32767 and -32768, ovf lane bit = 1. With SAT=0, outputs -32536 and 32536 with ovf = 1.
- Backpressure:
  - Stimulus: 8 back-to-back beats with out_ready toggled in a 1,0,0,1 pattern.
  - Required: 8 outputs in order with correct values, pixel_out stable while stalled, in_ready = 0 whenever out_valid=1 and out_ready=0.
- Bypass interleave:
  - Stimulus: beats with enable = 1,0,1 and bias_last=3.
  - Required: the bypass beat passes pixel_in unchanged with ovf=0; enabled beats use rows 0 then 1; row_ptr = 2 at the end.
- Write-during-read:
  - Stimulus: breg_we to row 0 on the same edge as a beat using row 0.
  - Required: that beat uses the old bias; the next sweep's row-0 beat uses the new bias.
- Reset mid-stream:
  - Stimulus: assert xrst with 2 beats in flight.
  - Required: out_valid = 0, pixel_out = 0, ovf = 0 and row_ptr = 0 immediately; a bank read after release returns 0, so the output equals the input.

Source files
------------

// File: rtl/bias_bank.sv
// Multi-lane bias adder with a DEPTH-row bias bank and an auto-advancing row pointer.
// Three register stages (capture, add, output) share one advance enable, so the pipeline stalls as a unit.
module bias_bank #(
    parameter int DWIDTH = 16,
    parameter int LANES  = 4,
    parameter int DEPTH  = 16,
    parameter int AWIDTH = 4,
    parameter int SAT    = 1
) (
    input  logic                      clk,
    input  logic                      xrst,
    input  logic                      enable,
    input  logic                      breg_we,
    input  logic [AWIDTH-1:0]         breg_addr,
    input  logic [LANES*DWIDTH-1:0]   read_bias,
    input  logic [AWIDTH-1:0]         bias_last,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DWIDTH-1:0]   pixel_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DWIDTH-1:0]   pixel_out,
    output logic [LANES-1:0]          ovf,
    output logic [AWIDTH-1:0]         row_ptr
);

    localparam int              W        = LANES * DWIDTH;
    localparam logic [AWIDTH:0] DEPTH_W  = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH-1:0] LAST_ROW = AWIDTH'(DEPTH - 1);
    localparam logic [AWIDTH-1:0] ONE_A    = AWIDTH'(1);
    localparam logic [AWIDTH-1:0] ZERO_A   = {AWIDTH{1'b0}};
    localparam logic              SAT_EN   = (SAT != 32'sd0);

    // Returns {overflow, result}; result is clamped or wrapped depending on SAT_EN.
    function automatic logic [DWIDTH:0] lane_add(input logic [DWIDTH-1:0] a,
                                                 input logic [DWIDTH-1:0] b);
        logic [DWIDTH:0]   s;
        logic              o;
        logic [DWIDTH-1:0] r;
        s = {a[DWIDTH-1], a} + {b[DWIDTH-1], b};
        o = s[DWIDTH] ^ s[DWIDTH-1];
        if (o && SAT_EN) begin
            r = s[DWIDTH] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
        end else begin
            r = s[DWIDTH-1:0];
        end
        return {o, r};
    endfunction

    logic [W-1:0]        bank_r [DEPTH];
    logic                advance_s;
    logic                fire_s;
    logic [AWIDTH-1:0]   ptr_eff_s;
    logic [AWIDTH-1:0]   last_eff_s;
    logic [AWIDTH-1:0]   ptr_next_s;
    logic [AWIDTH-1:0]   row_ptr_r;
    logic                s1_valid_r;
    logic                s1_en_r;
    logic [W-1:0]        s1_pix_r;
    logic [W-1:0]        s1_bias_r;
    logic                s2_valid_r;
    logic [W-1:0]        s2_data_r;
    logic [LANES-1:0]    s2_ovf_r;
    logic                out_valid_r;
    logic [W-1:0]        pixel_out_r;
    logic [LANES-1:0]    ovf_r;
    logic [W-1:0]        sum_s;
    logic [LANES-1:0]    sum_ovf_s;
    logic [DWIDTH:0]     lane_s;

    assign advance_s = !out_valid_r | out_ready;
    assign fire_s    = in_valid & advance_s;
    assign in_ready  = advance_s;
    assign out_valid = out_valid_r;
    assign pixel_out = pixel_out_r;
    assign ovf       = ovf_r;
    assign row_ptr   = row_ptr_r;

    // Row pointer: start forces row 0 for this cycle's beat; only enabled beats advance it.
    always_comb begin
        ptr_eff_s  = row_ptr_r;
        last_eff_s = bias_last;
        ptr_next_s = row_ptr_r;
        if (start) begin
            ptr_eff_s = ZERO_A;
        end else begin
            ptr_eff_s = row_ptr_r;
        end
        if ({1'b0, bias_last} >= DEPTH_W) begin
            last_eff_s = LAST_ROW;
        end else begin
            last_eff_s = bias_last;
        end
        if (fire_s && enable) begin
            ptr_next_s = (ptr_eff_s == last_eff_s) ? ZERO_A : ptr_eff_s + ONE_A;
        end else if (start) begin
            ptr_next_s = ZERO_A;
        end else begin
            ptr_next_s = row_ptr_r;
        end
    end

    // Per-lane add of the captured pixel and bias; bypass beats pass through untouched.
    always_comb begin
        sum_s     = {W{1'b0}};
        sum_ovf_s = {LANES{1'b0}};
        lane_s    = {(DWIDTH+1){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (s1_en_r) begin
                lane_s = lane_add(s1_pix_r[i*DWIDTH +: DWIDTH], s1_bias_r[i*DWIDTH +: DWIDTH]);
            end else begin
                lane_s = {1'b0, s1_pix_r[i*DWIDTH +: DWIDTH]};
            end
            sum_s[i*DWIDTH +: DWIDTH] = lane_s[DWIDTH-1:0];
            sum_ovf_s[i]              = lane_s[DWIDTH];
        end
    end

    // Bias bank write port; out-of-range addresses are dropped.
    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            for (int r = 0; r < DEPTH; r++) begin
                bank_r[r] <= {W{1'b0}};
            end
        end else if (breg_we && ({1'b0, breg_addr} < DEPTH_W)) begin
            bank_r[breg_addr] <= read_bias;
        end
    end

    // Row pointer register.
    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            row_ptr_r <= ZERO_A;
        end else begin
            row_ptr_r <= ptr_next_s;
        end
    end

    // Pipeline stages; everything moves together on advance so a stall freezes the outputs.
    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            s1_valid_r  <= 1'b0;
            s1_en_r     <= 1'b0;
            s1_pix_r    <= {W{1'b0}};
            s1_bias_r   <= {W{1'b0}};
            s2_valid_r  <= 1'b0;
            s2_data_r   <= {W{1'b0}};
            s2_ovf_r    <= {LANES{1'b0}};
            out_valid_r <= 1'b0;
            pixel_out_r <= {W{1'b0}};
            ovf_r       <= {LANES{1'b0}};
        end else if (advance_s) begin
            s1_valid_r  <= fire_s;
            if (fire_s) begin
                s1_en_r   <= enable;
                s1_pix_r  <= pixel_in;
                // Non-blocking read sees the row as it was before any same-edge write.
                s1_bias_r <= bank_r[ptr_eff_s];
            end
            s2_valid_r  <= s1_valid_r;
            if (s1_valid_r) begin
                s2_data_r <= sum_s;
                s2_ovf_r  <= sum_ovf_s;
            end
            out_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                pixel_out_r <= s2_data_r;
                ovf_r       <= s2_ovf_r;
            end
        end
    end

endmodule

// File: tb/tb_bias_bank.sv
// Bench for bias_bank: a saturating and a wrapping instance share all inputs and are
// checked against an arithmetic model of the bank, row pointer and per-beat result.
module tb_bias_bank;

    logic        clk = 1'b0;
    logic        xrst;
    logic        enable, breg_we, start, in_valid, out_ready;
    logic [3:0]  breg_addr, bias_last;
    logic [63:0] read_bias, pixel_in;
    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [63:0] pixel_out_a, pixel_out_b;
    logic [3:0]  ovf_a, ovf_b, row_ptr_a, row_ptr_b;

    bias_bank #(.DWIDTH(16), .LANES(4), .DEPTH(16), .AWIDTH(4), .SAT(1)) u_sat (
        .clk(clk), .xrst(xrst), .enable(enable), .breg_we(breg_we), .breg_addr(breg_addr),
        .read_bias(read_bias), .bias_last(bias_last), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_a), .pixel_in(pixel_in), .out_valid(out_valid_a),
        .out_ready(out_ready), .pixel_out(pixel_out_a), .ovf(ovf_a), .row_ptr(row_ptr_a));

    bias_bank #(.DWIDTH(16), .LANES(4), .DEPTH(16), .AWIDTH(4), .SAT(0)) u_wrap (
        .clk(clk), .xrst(xrst), .enable(enable), .breg_we(breg_we), .breg_addr(breg_addr),
        .read_bias(read_bias), .bias_last(bias_last), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_b), .pixel_in(pixel_in), .out_valid(out_valid_b),
        .out_ready(out_ready), .pixel_out(pixel_out_b), .ovf(ovf_b), .row_ptr(row_ptr_b));

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] sat_pix;
        logic [63:0] wrap_pix;
        logic [3:0]  ovf;
    } exp_t;

    int                 n_vec = 0;
    int                 n_err = 0;
    logic signed [15:0] bank_m [16][4];
    int                 ptr_m;
    exp_t               q[$];
    logic               last_fire;
    logic               stalled_prev;
    logic [63:0]        held_pix;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    // Expected result of one beat from plain integer arithmetic.
    function automatic exp_t model_beat(input logic [63:0] pix, input logic en, input int row);
        exp_t e;
        int   p, b, s, c;
        e.sat_pix  = 64'd0;
        e.wrap_pix = 64'd0;
        e.ovf      = 4'd0;
        for (int l = 0; l < 4; l++) begin
            p = $signed(pix[l*16 +: 16]);
            b = bank_m[row][l];
            if (!en) begin
                e.sat_pix[l*16 +: 16]  = pix[l*16 +: 16];
                e.wrap_pix[l*16 +: 16] = pix[l*16 +: 16];
            end else begin
                s = p + b;
                c = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
                e.sat_pix[l*16 +: 16]  = 16'(c);
                e.wrap_pix[l*16 +: 16] = 16'(s);
                e.ovf[l]               = (s > 32767) || (s < -32768);
            end
        end
        return e;
    endfunction

    function automatic void clear_model();
        for (int r = 0; r < 16; r++) begin
            for (int l = 0; l < 4; l++) bank_m[r][l] = 16'sd0;
        end
        ptr_m = 0;
        q.delete();
        stalled_prev = 1'b0;
    endfunction

    // One clock: check outputs, update the model on handshakes, then step to the next negedge.
    task automatic tick();
        exp_t e;
        int   row;
        #1;
        chk("in_ready_rule", in_ready_a, !out_valid_a | out_ready);
        chk("row_ptr_sat", row_ptr_a, ptr_m);
        chk("row_ptr_wrap", row_ptr_b, ptr_m);
        if (stalled_prev) chk("stall_hold", pixel_out_a, held_pix);
        if (out_valid_a && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", out_valid_a, 1'b0);
            end else begin
                e = q.pop_front();
                chk("pix_sat", pixel_out_a, e.sat_pix);
                chk("pix_wrap", pixel_out_b, e.wrap_pix);
                chk("ovf_sat", ovf_a, e.ovf);
                chk("ovf_wrap", ovf_b, e.ovf);
                chk("valid_wrap", out_valid_b, 1'b1);
            end
        end
        last_fire = in_valid && in_ready_a;
        if (last_fire) begin
            row = start ? 0 : ptr_m;
            q.push_back(model_beat(pixel_in, enable, row));
            if (enable) ptr_m = (row == int'(bias_last)) ? 0 : (row + 1) % 16;
            else if (start) ptr_m = 0;
        end else if (start) begin
            ptr_m = 0;
        end
        if (breg_we) begin
            for (int l = 0; l < 4; l++) bank_m[breg_addr][l] = read_bias[l*16 +: 16];
        end
        stalled_prev = out_valid_a && !out_ready;
        held_pix     = pixel_out_a;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr_row(input logic [3:0] addr, input logic [63:0] data);
        breg_we = 1'b1; breg_addr = addr; read_bias = data; in_valid = 1'b0;
        tick();
        breg_we = 1'b0;
    endtask

    task automatic beat(input logic [63:0] pix, input logic en, input logic st);
        in_valid = 1'b1; pixel_in = pix; enable = en; start = st;
        tick();
        in_valid = 1'b0; start = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0; start = 1'b0; breg_we = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() > 0; i++) tick();
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] bp_pix [8];
        int          sent, cyc;
        xrst = 1'b1; enable = 1'b0; breg_we = 1'b0; start = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1; breg_addr = 4'd0; bias_last = 4'd0; read_bias = 64'd0; pixel_in = 64'd0;
        clear_model();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid_a, 1'b0);
        chk("rst_pixel_out", pixel_out_a, 64'd0);
        chk("rst_ovf", ovf_a, 4'd0);
        chk("rst_row_ptr", row_ptr_a, 4'd0);
        xrst = 1'b0;

        // Basic add with a two-row sweep and latency check.
        wr_row(4'd0, pk(1, 2, 3, 4));
        wr_row(4'd1, pk(-1, -2, -3, -4));
        bias_last = 4'd1; start = 1'b1; tick(); start = 1'b0;
        beat(pk(10, 10, 10, 10), 1'b1, 1'b0);
        chk("lat_edge1", out_valid_a, 1'b0);
        beat(pk(10, 10, 10, 10), 1'b1, 1'b0);
        chk("lat_edge2", out_valid_a, 1'b0);
        beat(pk(10, 10, 10, 10), 1'b1, 1'b0);
        chk("lat_edge3", out_valid_a, 1'b1);
        chk("basic_first", pixel_out_a, pk(11, 12, 13, 14));
        beat(pk(10, 10, 10, 10), 1'b1, 1'b0);
        drain();

        // Saturation and wrap at both extremes.
        wr_row(4'd0, pk(1000, -1000, 0, 0));
        bias_last = 4'd0;
        beat(pk(32000, -32000, 5, -5), 1'b1, 1'b1);
        tick(); tick();
        chk("sat_valid", out_valid_a, 1'b1);
        chk("sat_pix", pixel_out_a, pk(32767, -32768, 5, -5));
        chk("wrap_pix_dir", pixel_out_b, pk(-32536, 32536, 5, -5));
        chk("sat_ovf", ovf_a, 4'b0011);
        chk("wrap_ovf", ovf_b, 4'b0011);
        drain();

        // Backpressure with out_ready cycling 1,0,0,1.
        for (int r = 0; r < 4; r++) wr_row(4'(r), {$urandom, $urandom});
        for (int i = 0; i < 8; i++) bp_pix[i] = {$urandom, $urandom};
        bias_last = 4'd3; start = 1'b1; tick(); start = 1'b0;
        sent = 0; cyc = 0;
        while (sent < 8 && cyc < 100) begin
            in_valid = 1'b1; pixel_in = bp_pix[sent]; enable = 1'b1;
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            tick();
            if (last_fire) sent++;
            cyc++;
        end
        chk("bp_sent", sent, 8);
        drain();

        // Bypass interleave: enabled beats take rows 0 and 1, bypass leaves pointer alone.
        beat({$urandom, $urandom}, 1'b1, 1'b1);
        beat({$urandom, $urandom}, 1'b0, 1'b0);
        beat({$urandom, $urandom}, 1'b1, 1'b0);
        chk("bypass_ptr", row_ptr_a, 4'd2);
        drain();

        // Write-during-read on row 0.
        wr_row(4'd0, pk(100, 100, 100, 100));
        bias_last = 4'd0; start = 1'b1; tick(); start = 1'b0;
        breg_we = 1'b1; breg_addr = 4'd0; read_bias = pk(200, 200, 200, 200);
        beat(pk(1, 1, 1, 1), 1'b1, 1'b0);
        breg_we = 1'b0;
        beat(pk(1, 1, 1, 1), 1'b1, 1'b0);
        tick();
        chk("wdr_old", pixel_out_a, pk(101, 101, 101, 101));
        tick();
        chk("wdr_new", pixel_out_a, pk(201, 201, 201, 201));
        drain();

        // Reset with beats in flight.
        for (int r = 0; r < 4; r++) wr_row(4'(r), pk(r + 1, r + 2, r + 3, r + 4));
        bias_last = 4'd3;
        beat(pk(50, 60, 70, 80), 1'b1, 1'b1);
        beat(pk(51, 61, 71, 81), 1'b1, 1'b0);
        beat(pk(52, 62, 72, 82), 1'b1, 1'b0);
        xrst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid_a, 1'b0);
        chk("mid_rst_pix", pixel_out_a, 64'd0);
        chk("mid_rst_ovf", ovf_a, 4'd0);
        chk("mid_rst_ptr", row_ptr_a, 4'd0);
        clear_model();
        @(posedge clk); @(negedge clk);
        xrst = 1'b0;
        beat(pk(7, 8, 9, 10), 1'b1, 1'b0);
        tick(); tick();
        chk("post_rst_pass", pixel_out_a, pk(7, 8, 9, 10));
        drain();

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            pixel_in  = {$urandom, $urandom};
            enable    = ($urandom_range(0, 4) != 0);
            breg_we   = ($urandom_range(0, 7) == 0);
            breg_addr = 4'($urandom_range(0, 15));
            read_bias = {$urandom, $urandom};
            start     = ($urandom_range(0, 19) == 0);
            if (start) bias_last = 4'($urandom_range(0, 15));
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
